// File: rtl/mux_sel_pipe.sv
// Registered N-channel selector with valid/ready handshake.
// Selection is either an explicit index (mode=0) or round-robin across valid channels (mode=1).
module mux_sel_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;
    logic [SELW-1:0]  r_last;

    logic             w_can_load;
    logic             w_grant_valid;
    logic [SELW-1:0]  w_grant_idx;
    logic [NCH-1:0]   w_in_ready;
    logic [WIDTH-1:0] w_sel_data;

    assign w_can_load = !r_out_valid || out_ready;

    // rst_n gates the grant so in_ready stays low for the whole reset window.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        if (rst_n && w_can_load) begin
            if (!mode) begin
                for (int k = 0; k < NCH; k++) begin
                    if (sel == SELW'(k) && in_valid[k]) begin
                        w_grant_valid = 1'b1;
                        w_grant_idx   = SELW'(k);
                    end
                end
            end else begin
                // Walk the search order backwards so the earliest hit wins.
                for (int i = NCH; i >= 1; i--) begin
                    if (in_valid[(int'(r_last) + i) % NCH]) begin
                        w_grant_valid = 1'b1;
                        w_grant_idx   = SELW'((int'(r_last) + i) % NCH);
                    end
                end
            end
        end
    end

    always_comb begin
        w_in_ready = '0;
        w_sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_grant_valid && w_grant_idx == SELW'(k)) begin
                w_in_ready[k] = 1'b1;
                w_sel_data    = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_last      <= SELW'(NCH - 1);
        end else if (w_grant_valid) begin
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_grant_idx;
            r_out_valid <= 1'b1;
            r_last      <= w_grant_idx;
        end else if (w_can_load) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
